// File: rtl/fifo_scoreboard_checker.sv
// In-order scoreboard for a FIFO under test. Expected words are queued; each
// observed word pops the queue head and is compared. Verdicts are registered
// one-cycle pulses plus saturating tallies and sticky error flags.
module fifo_scoreboard_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_counts,
    input  logic                    exp_valid,
    input  logic [DATA_WIDTH-1:0]   exp_data,
    input  logic                    act_valid,
    input  logic [DATA_WIDTH-1:0]   act_data,
    output logic                    pass_pulse,
    output logic                    fail_pulse,
    output logic [CNT_WIDTH-1:0]    pass_count,
    output logic [CNT_WIDTH-1:0]    fail_count,
    output logic [$clog2(DEPTH):0]  q_level,
    output logic                    underflow,
    output logic                    overflow,
    output logic [DATA_WIDTH-1:0]   fail_exp,
    output logic [DATA_WIDTH-1:0]   fail_act
);
    // Handshake: exp_valid and act_valid are single-cycle qualifiers with no
    // back-pressure; a word is consumed on every rising edge its valid is high.

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  pass_pulse_q, pass_pulse_d;
    logic                  fail_pulse_q, fail_pulse_d;
    logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
    logic                  underflow_q, underflow_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;

    logic [DATA_WIDTH-1:0] head;
    logic q_empty, q_full, do_pop, do_push, do_drop;
    logic chk_pass, chk_fail, chk_under;

    // Decode this cycle's events from queue state before any same-cycle push.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        q_empty   = (level_q == '0);
        q_full    = (level_q == FULL_LEVEL);
        do_pop    = act_valid && !q_empty;
        chk_under = act_valid && q_empty;
        chk_pass  = do_pop && (head == act_data);
        chk_fail  = act_valid && !chk_pass;
        do_push   = exp_valid && (!q_full || do_pop);
        do_drop   = exp_valid && q_full && !do_pop;
    end

    // Next-state for pointers, level, verdict pulses, tallies and sticky flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        pass_pulse_d = chk_pass;
        fail_pulse_d = chk_fail;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        underflow_d  = underflow_q;
        overflow_d   = overflow_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;

        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A clear wins over a verdict on the same edge; the pulse still fires.
        if (clr_counts) begin
            pass_cnt_d  = '0;
            fail_cnt_d  = '0;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
            fail_exp_d  = '0;
            fail_act_d  = '0;
        end else begin
            if (chk_pass && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
            if (chk_fail && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
            if (chk_fail) begin
                fail_exp_d = chk_under ? '0 : head;
                fail_act_d = act_data;
            end
            if (chk_under) underflow_d = 1'b1;
            if (do_drop)   overflow_d  = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pass_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
        end
    end

    // Reference queue storage; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wr_ptr_q] <= exp_data;
    end

    assign pass_pulse = pass_pulse_q;
    assign fail_pulse = fail_pulse_q;
    assign pass_count = pass_cnt_q;
    assign fail_count = fail_cnt_q;
    assign q_level    = level_q;
    assign underflow  = underflow_q;
    assign overflow   = overflow_q;
    assign fail_exp   = fail_exp_q;
    assign fail_act   = fail_act_q;

endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// Bench for fifo_scoreboard_checker: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_fifo_scoreboard_checker;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n, clr_counts, exp_valid, act_valid;
    logic [DW-1:0] exp_data, act_data;
    logic          pass_pulse, fail_pulse, underflow, overflow;
    logic [15:0]   pass_count, fail_count;
    logic [3:0]    q_level;
    logic [DW-1:0] fail_exp, fail_act;
    logic          s_pass_pulse, s_fail_pulse, s_underflow, s_overflow;
    logic [3:0]    s_pass_count, s_fail_count;
    logic [3:0]    s_q_level;
    logic [DW-1:0] s_fail_exp, s_fail_act;

    fifo_scoreboard_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr_counts(clr_counts),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .act_valid(act_valid), .act_data(act_data),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .pass_count(pass_count), .fail_count(fail_count),
        .q_level(q_level), .underflow(underflow), .overflow(overflow),
        .fail_exp(fail_exp), .fail_act(fail_act)
    );

    fifo_scoreboard_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .clr_counts(clr_counts),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .act_valid(act_valid), .act_data(act_data),
        .pass_pulse(s_pass_pulse), .fail_pulse(s_fail_pulse),
        .pass_count(s_pass_count), .fail_count(s_fail_count),
        .q_level(s_q_level), .underflow(s_underflow), .overflow(s_overflow),
        .fail_exp(s_fail_exp), .fail_act(s_fail_act)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    int            m_pcnt, m_fcnt;
    logic          m_pass, m_fail, m_under, m_over;
    logic [DW-1:0] m_fexp, m_fact;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One clock edge of the scoreboard rules expressed on a queue.
    task automatic model_edge(input logic r, input logic c, input logic ev, input logic [DW-1:0] ed,
                              input logic av, input logic [DW-1:0] ad);
        logic p, f, uf, of;
        logic [DW-1:0] fe, h;
        if (!r) begin
            exp_q.delete();
            m_pcnt = 0; m_fcnt = 0; m_pass = 0; m_fail = 0;
            m_under = 0; m_over = 0; m_fexp = '0; m_fact = '0;
        end else begin
            p = 0; f = 0; uf = 0; of = 0; fe = '0;
            if (av) begin
                if (exp_q.size() > 0) begin
                    h = exp_q.pop_front();
                    if (h == ad) p = 1;
                    else begin f = 1; fe = h; end
                end else begin
                    f = 1; uf = 1;
                end
            end
            if (ev) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(ed);
                else of = 1;
            end
            m_pass = p; m_fail = f;
            if (c) begin
                m_pcnt = 0; m_fcnt = 0; m_under = 0; m_over = 0; m_fexp = '0; m_fact = '0;
            end else begin
                if (p) m_pcnt++;
                if (f) begin m_fcnt++; m_fexp = fe; m_fact = ad; end
                if (uf) m_under = 1;
                if (of) m_over = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("pass_pulse", 32'(pass_pulse), 32'(m_pass));
        check("fail_pulse", 32'(fail_pulse), 32'(m_fail));
        check("pass_count", 32'(pass_count), 32'(sat(m_pcnt, 16)));
        check("fail_count", 32'(fail_count), 32'(sat(m_fcnt, 16)));
        check("q_level",    32'(q_level),    32'(exp_q.size()));
        check("underflow",  32'(underflow),  32'(m_under));
        check("overflow",   32'(overflow),   32'(m_over));
        check("fail_exp",   32'(fail_exp),   32'(m_fexp));
        check("fail_act",   32'(fail_act),   32'(m_fact));
        check("s_pass_count", 32'(s_pass_count), 32'(sat(m_pcnt, 4)));
        check("s_fail_count", 32'(s_fail_count), 32'(sat(m_fcnt, 4)));
    endtask

    // Driver: apply inputs, advance one edge, update model, compare at negedge.
    task automatic do_cycle(input logic r, input logic c, input logic ev, input logic [DW-1:0] ed,
                            input logic av, input logic [DW-1:0] ad);
        rst_n = r; clr_counts = c; exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad;
        @(posedge clk);
        model_edge(r, c, ev, ed, av, ad);
        @(negedge clk);
        compare_all();
    endtask

    typedef struct {
        logic          ev;
        logic [DW-1:0] ed;
        logic          av;
        logic [DW-1:0] ad;
        logic          e_pass;
        logic          e_fail;
        logic [3:0]    e_level;
        logic          e_under;
        logic [DW-1:0] e_fexp;
        logic [DW-1:0] e_fact;
        int            e_pcnt;
        int            e_fcnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b0, 16'h0000, 16'h0000, 0, 0};
        vecs[1]  = '{1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd2, 1'b0, 16'h0000, 16'h0000, 0, 0};
        vecs[2]  = '{1'b1, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd3, 1'b0, 16'h0000, 16'h0000, 0, 0};
        vecs[3]  = '{1'b1, 16'h0004, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd4, 1'b0, 16'h0000, 16'h0000, 0, 0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 4'd3, 1'b0, 16'h0000, 16'h0000, 1, 0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b0, 4'd2, 1'b0, 16'h0000, 16'h0000, 2, 0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0000, 16'h0000, 3, 0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000, 4, 0};
        vecs[8]  = '{1'b1, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b0, 16'h0000, 16'h0000, 4, 0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 16'hAAAB, 1'b0, 1'b1, 4'd0, 1'b0, 16'hAAAA, 16'hAAAB, 4, 1};
        vecs[10] = '{1'b1, 16'h1234, 1'b1, 16'h5555, 1'b0, 1'b1, 4'd1, 1'b1, 16'h0000, 16'h5555, 4, 2};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h5555, 5, 2};

        // Reset
        do_cycle(0, 0, 0, '0, 0, '0);
        do_cycle(0, 0, 0, '0, 0, '0);
        check("rst_q_level", 32'(q_level), 32'd0);
        check("rst_pass_count", 32'(pass_count), 32'd0);

        // Directed vectors: in-order passes, mismatch, underflow with same-cycle push
        for (int i = 0; i < 12; i++) begin
            do_cycle(1, 0, vecs[i].ev, vecs[i].ed, vecs[i].av, vecs[i].ad);
            check($sformatf("tbl%0d_pass", i),  32'(pass_pulse), 32'(vecs[i].e_pass));
            check($sformatf("tbl%0d_fail", i),  32'(fail_pulse), 32'(vecs[i].e_fail));
            check($sformatf("tbl%0d_level", i), 32'(q_level),    32'(vecs[i].e_level));
            check($sformatf("tbl%0d_under", i), 32'(underflow),  32'(vecs[i].e_under));
            check($sformatf("tbl%0d_fexp", i),  32'(fail_exp),   32'(vecs[i].e_fexp));
            check($sformatf("tbl%0d_fact", i),  32'(fail_act),   32'(vecs[i].e_fact));
            check($sformatf("tbl%0d_pcnt", i),  32'(pass_count), 32'(vecs[i].e_pcnt));
            check($sformatf("tbl%0d_fcnt", i),  32'(fail_count), 32'(vecs[i].e_fcnt));
        end

        // Overflow: nine pushes into eight entries, drain eight matching
        do_cycle(1, 1, 0, '0, 0, '0);
        check("clr_underflow", 32'(underflow), 32'd0);
        for (int k = 0; k < 9; k++) do_cycle(1, 0, 1, DW'(16'h4000 + k), 0, '0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_level", 32'(q_level), 32'd8);
        for (int k = 0; k < 8; k++) begin
            do_cycle(1, 0, 0, '0, 1, DW'(16'h4000 + k));
            check("ovf_drain_pass", 32'(pass_pulse), 32'd1);
        end
        check("ovf_drain_level", 32'(q_level), 32'd0);
        check("ovf_drain_count", 32'(pass_count), 32'd8);

        // Full queue with simultaneous push and pop, pointers wrap
        do_cycle(1, 1, 0, '0, 0, '0);
        for (int k = 0; k < 8; k++) do_cycle(1, 0, 1, DW'(16'h5000 + k), 0, '0);
        for (int k = 0; k < 20; k++) begin
            do_cycle(1, 0, 1, DW'(16'h5008 + k), 1, DW'(16'h5000 + k));
            check("wrap_level", 32'(q_level), 32'd8);
            check("wrap_pass", 32'(pass_pulse), 32'd1);
        end
        for (int k = 0; k < 8; k++) do_cycle(1, 0, 0, '0, 1, DW'(16'h5014 + k));
        check("wrap_count", 32'(pass_count), 32'd28);
        check("wrap_ovf", 32'(overflow), 32'd0);

        // Saturation on the narrow instance, then reset mid-stream
        do_cycle(1, 1, 0, '0, 0, '0);
        for (int k = 0; k < 20; k++) begin
            do_cycle(1, 0, 1, DW'(16'h6000 + k), 0, '0);
            do_cycle(1, 0, 0, '0, 1, DW'(16'h6000 + k));
        end
        check("sat_small", 32'(s_pass_count), 32'd15);
        check("sat_wide", 32'(pass_count), 32'd20);
        for (int k = 0; k < 3; k++) do_cycle(1, 0, 1, DW'(16'h7000 + k), 0, '0);
        do_cycle(1, 0, 0, '0, 1, 16'h7000);
        check("pre_rst_pass", 32'(pass_pulse), 32'd1);
        do_cycle(0, 0, 1, 16'h7777, 1, 16'h7001);
        check("rst_no_pass", 32'(pass_pulse), 32'd0);
        check("rst_no_fail", 32'(fail_pulse), 32'd0);
        check("rst_counts", 32'(s_pass_count), 32'd0);
        check("rst_level", 32'(q_level), 32'd0);
        do_cycle(1, 0, 0, '0, 0, '0);
        check("post_rst_pass", 32'(pass_pulse), 32'd0);
        check("post_rst_fail", 32'(fail_pulse), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic r, c, ev, av;
            logic [DW-1:0] ed, ad;
            r  = ($urandom_range(0, 299) != 0);
            c  = ($urandom_range(0, 49) == 0);
            ev = ($urandom_range(0, 99) < 55);
            av = ($urandom_range(0, 99) < 50);
            ed = DW'($urandom);
            if (exp_q.size() > 0 && $urandom_range(0, 99) < 80) ad = exp_q[0];
            else ad = DW'($urandom);
            do_cycle(r, c, ev, ed, av, ad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
